// File: rtl/motion_sensor_frontend_if.sv
// Signal bundle between the PIR front end and its consumer.
// master drives enable/pir_raw; slave (the front end) returns the qualified motion outputs.
interface motion_sensor_frontend_if;
    logic       enable;
    logic       pir_raw;
    logic       motion_detected;
    logic       motion_event;
    logic [7:0] event_count;
    logic [7:0] glitch_count;

    modport master (
        output enable,
        output pir_raw,
        input  motion_detected,
        input  motion_event,
        input  event_count,
        input  glitch_count
    );

    modport slave (
        input  enable,
        input  pir_raw,
        output motion_detected,
        output motion_event,
        output event_count,
        output glitch_count
    );
endinterface

// File: rtl/motion_sensor_frontend.sv
// PIR front end: synchroniser, debounce, hold stretch and cooldown blanking, with event counting.
// Optional rejected-pulse counter is built only when MOTION_GLITCH_CNT_EN is defined.
module motion_sensor_frontend #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 20,
    parameter int unsigned COOLDOWN_CYCLES = 10,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    motion_sensor_frontend_if.slave  sif
);

    typedef enum logic [2:0] {
        IDLE,
        QUALIFY,
        ACTIVE,
        HOLD,
        COOLDOWN
    } state_t;

    localparam logic [CNT_W-1:0] T_ZERO   = '0;
    localparam logic [CNT_W-1:0] T_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HLD_LAST = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CDN_LAST = CNT_W'(COOLDOWN_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pir_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       timer_q, timer_d;
    logic                   event_d;
    logic                   md_d;
    logic                   md_q;
    logic                   event_q;
    logic [7:0]             event_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sif.pir_raw};
        end
    end

    assign pir_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= T_ZERO;
            md_q    <= 1'b0;
            event_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            md_q    <= md_d;
            event_q <= event_d;
        end
    end

    // HOLD gives retrigger priority over expiry so a returning PIR keeps md high without a gap.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        event_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pir_s) begin
                    state_d = QUALIFY;
                    timer_d = T_ONE;
                end
            end
            QUALIFY: begin
                if (!pir_s) begin
                    state_d = IDLE;
                    timer_d = T_ZERO;
                end else if (timer_q == DEB_LAST) begin
                    state_d = ACTIVE;
                    timer_d = T_ZERO;
                    event_d = 1'b1;
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            ACTIVE: begin
                if (!pir_s) begin
                    state_d = HOLD;
                    timer_d = T_ONE;
                end
            end
            HOLD: begin
                if (pir_s) begin
                    state_d = ACTIVE;
                    timer_d = T_ZERO;
                end else if (timer_q == HLD_LAST) begin
                    state_d = COOLDOWN;
                    timer_d = T_ONE;
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            COOLDOWN: begin
                if (timer_q == CDN_LAST) begin
                    state_d = IDLE;
                    timer_d = T_ZERO;
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = T_ZERO;
            end
        endcase
        if (!sif.enable) begin
            state_d = IDLE;
            timer_d = T_ZERO;
            event_d = 1'b0;
        end
    end

    assign md_d = (state_d == ACTIVE) || (state_d == HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            event_count_q <= 8'h00;
        end else if (event_d && (event_count_q != 8'hFF)) begin
            event_count_q <= event_count_q + 8'd1;
        end
    end

    assign sif.motion_detected = md_q;
    assign sif.motion_event    = event_q;
    assign sif.event_count     = event_count_q;

`ifdef MOTION_GLITCH_CNT_EN
    logic       glitch_hit;
    logic [7:0] glitch_count_q;

    // Enable-forced exits from QUALIFY are deliberately not counted as glitches.
    assign glitch_hit = sif.enable && (state_q == QUALIFY) && !pir_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_count_q <= 8'h00;
        end else if (glitch_hit && (glitch_count_q != 8'hFF)) begin
            glitch_count_q <= glitch_count_q + 8'd1;
        end
    end

    assign sif.glitch_count = glitch_count_q;
`else
    assign sif.glitch_count = 8'h00;
`endif

endmodule
